// File: rtl/spi_display_sequencer.sv
// spi_display_sequencer
//   Instruction-driven controller for the SPI display link. Fetches 18-bit
//   instructions from an external synchronous program ROM and executes them:
//     00 CMD   : shift payload[WORD_BITS-1:0] out MSB first with dc=1
//     01 DATA  : same, with dc=0
//     10 DELAY : wait payload sclkEdge ticks with cs released
//     11 HALT  : release cs, pulse done, return to idle
//
// Ports
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   start    : one-cycle pulse, starts execution from address 0 when idle
//   sclkEdge : one-cycle pulse per SCLK launch edge from the divider
//   instr    : instruction at the current PC (valid one clk after pcEn/pcRst)
//   pcEn     : one-cycle pulse, PC increments
//   pcRst    : one-cycle pulse, PC clears to 0
//   cs       : display chip select, active low
//   dc       : 1 = command, 0 = data
//   mosi     : serial data, MSB first
//   busy     : high whenever the sequencer is not idle
//   done     : one-cycle pulse when HALT executes
//
// All outputs are registered, so every output change appears the cycle after
// the state that decides it (pcRst/pcEn are high during WAIT, and the ROM
// word for the new PC is therefore present in DECODE).
module spi_display_sequencer #(
  parameter int WORD_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sclkEdge,
  input  logic [17:0] instr,
  output logic        pcEn,
  output logic        pcRst,
  output logic        cs,
  output logic        dc,
  output logic        mosi,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DECODE,
    S_SHIFT,
    S_DELAY,
    S_NEXT
  } state_t;

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  // Index of the final bit of a word; bitCnt is 4 bits wide for WORD_BITS <= 16.
  localparam logic [3:0] LAST_BIT = 4'(WORD_BITS - 1);

  state_t               state;
  logic [WORD_BITS-1:0] shreg;
  logic [WORD_BITS-1:0] shifted;
  logic [3:0]           bitCnt;
  logic [15:0]          delayCnt;
  logic [1:0]           opcode;
  logic [15:0]          payload;

  assign opcode  = instr[17:16];
  assign payload = instr[15:0];
  assign shifted = shreg << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cs       <= 1'b1;
      dc       <= 1'b1;
      mosi     <= 1'b0;
      pcEn     <= 1'b0;
      pcRst    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bitCnt   <= '0;
      delayCnt <= '0;
      shreg    <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      pcEn  <= 1'b0;
      pcRst <= 1'b0;
      done  <= 1'b0;

      case (state)
        S_IDLE: begin
          cs   <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            pcRst <= 1'b1;
            busy  <= 1'b1;
            state <= S_WAIT;
          end
        end

        // One cycle for the ROM to present the word at the new PC.
        S_WAIT: state <= S_DECODE;

        S_DECODE: begin
          case (opcode)
            OP_CMD, OP_DATA: begin
              shreg  <= payload[WORD_BITS-1:0];
              dc     <= (opcode == OP_CMD);
              cs     <= 1'b0;
              mosi   <= payload[WORD_BITS-1];
              bitCnt <= '0;
              state  <= S_SHIFT;
            end
            OP_DELAY: begin
              cs       <= 1'b1;
              delayCnt <= payload;
              state    <= (payload == 16'd0) ? S_NEXT : S_DELAY;
            end
            default: begin  // OP_HALT
              cs    <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          endcase
        end

        // The MSB went out in DECODE; each tick launches the next bit, and the
        // tick after the last bit closes the word.
        S_SHIFT: begin
          if (sclkEdge) begin
            if (bitCnt == LAST_BIT) begin
              state <= S_NEXT;
            end else begin
              shreg  <= shifted;
              mosi   <= shifted[WORD_BITS-1];
              bitCnt <= bitCnt + 4'd1;
            end
          end
        end

        S_DELAY: begin
          if (sclkEdge) begin
            delayCnt <= delayCnt - 16'd1;
            if (delayCnt == 16'd1) state <= S_NEXT;
          end
        end

        S_NEXT: begin
          pcEn  <= 1'b1;
          state <= S_WAIT;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_display_sequencer.sv
module tb_spi_display_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset  = 1'b1;
  logic start  = 1'b0;
  logic start9 = 1'b0;

  // SCLK divider stand-in: one tick every 8 clocks.
  logic [2:0] div = '0;
  logic       sclkEdge;
  always @(posedge clk) div <= div + 3'd1;
  assign sclkEdge = (div == 3'd7);

  // Program ROM and PC for the 8-bit instance.
  logic [17:0] rom8 [0:15];
  logic [3:0]  pc8 = '0;
  logic [17:0] instr8;
  logic pcEn8, pcRst8, cs8, dc8, mosi8, busy8, done8;
  always @(posedge clk) begin
    if (pcRst8)     pc8 <= '0;
    else if (pcEn8) pc8 <= pc8 + 4'd1;
  end
  assign instr8 = rom8[pc8];

  // Program ROM and PC for the 9-bit instance.
  logic [17:0] rom9 [0:3];
  logic [1:0]  pc9 = '0;
  logic [17:0] instr9;
  logic pcEn9, pcRst9, cs9, dc9, mosi9, busy9, done9;
  always @(posedge clk) begin
    if (pcRst9)     pc9 <= '0;
    else if (pcEn9) pc9 <= pc9 + 2'd1;
  end
  assign instr9 = rom9[pc9];

  spi_display_sequencer #(.WORD_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .sclkEdge(sclkEdge), .instr(instr8),
    .pcEn(pcEn8), .pcRst(pcRst8), .cs(cs8), .dc(dc8), .mosi(mosi8),
    .busy(busy8), .done(done8)
  );

  spi_display_sequencer #(.WORD_BITS(9)) dut9 (
    .clk(clk), .reset(reset), .start(start9), .sclkEdge(sclkEdge), .instr(instr9),
    .pcEn(pcEn9), .pcRst(pcRst9), .cs(cs9), .dc(dc9), .mosi(mosi9),
    .busy(busy9), .done(done9)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic [1:0] op, input logic [15:0] pl);
    return {op, pl};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom8[i] = mk(2'b11, 16'h0);
  endtask

  // ---------------- transaction-level model ----------------
  // Walks the program and lists what the link must show: one {dc,bit} per
  // consumed SCLK tick, the tick count of every cs-high gap between words,
  // and how many PC increments precede HALT.
  logic [1:0] exp_bits [$];
  int         exp_gaps [$];
  int         exp_pcen;

  task automatic build_model();
    int acc;
    bit pending, seen;
    logic [1:0]  op;
    logic [15:0] pl;
    exp_bits.delete();
    exp_gaps.delete();
    exp_pcen = 0;
    acc = 0; pending = 0; seen = 0;
    for (int i = 0; i < 16; i++) begin
      op = rom8[i][17:16];
      pl = rom8[i][15:0];
      if (op == 2'b11) break;
      exp_pcen++;
      if (op[1] == 1'b0) begin
        if (pending && seen) exp_gaps.push_back(acc);
        pending = 0; acc = 0; seen = 1;
        for (int b = 7; b >= 0; b--) exp_bits.push_back({op == 2'b00, pl[b]});
      end else begin
        pending = 1;
        acc += int'(pl);
      end
    end
  endtask

  // ---------------- monitor / compare ----------------
  logic        mon_on = 1'b0;
  int          cnt_pcen, cnt_pcrst, cnt_done, cnt_edges;
  int          gap_edges, gap_cyc, last_gap_cyc;
  bit          seen_byte, prev_cs;
  logic [31:0] got_bits;

  task automatic mon_clear();
    cnt_pcen = 0; cnt_pcrst = 0; cnt_done = 0; cnt_edges = 0;
    gap_edges = 0; gap_cyc = 0; last_gap_cyc = -1;
    seen_byte = 0; prev_cs = 1; got_bits = '0;
  endtask

  initial begin : monitor
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (pcEn8 || pcRst8) chk("pcEn_pcRst_exclusive", {pcEn8, pcRst8} == 2'b11, 0);
        cnt_pcen  += int'(pcEn8);
        cnt_pcrst += int'(pcRst8);
        cnt_done  += int'(done8);
        if (sclkEdge && !cs8 && busy8) begin
          if (exp_bits.size() == 0) begin
            chk("extra_bit", 1, 0);
          end else begin
            e = exp_bits.pop_front();
            chk("mosi", mosi8, e[0]);
            chk("dc", dc8, e[1]);
          end
          got_bits = {got_bits[30:0], mosi8};
          cnt_edges++;
        end
        if (busy8 && cs8 && seen_byte) begin
          gap_cyc++;
          if (sclkEdge) gap_edges++;
        end
        if (!cs8 && prev_cs && seen_byte) begin
          if (exp_gaps.size() == 0) chk("unexpected_cs_gap", gap_edges, 32'hFFFF_FFFF);
          else chk("cs_gap_ticks", gap_edges, exp_gaps.pop_front());
          last_gap_cyc = gap_cyc;
          gap_edges = 0;
          gap_cyc = 0;
        end
        if (!cs8) seen_byte = 1;
        prev_cs = cs8;
      end
    end
  end

  // Start so that the WAIT cycle coincides with an sclkEdge tick.
  task automatic align_start();
    @(negedge clk);
    while (div != 3'd6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run8(input string tag, input bit restart);
    int t;
    build_model();
    mon_clear();
    mon_on = 1'b1;
    align_start();
    t = 0;
    while (cnt_done == 0 && t < 1000) begin
      start = (restart && t == 40);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    chk({tag, "_done_in_time"}, t < 1000, 1);
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    chk({tag, "_pcEn_count"}, cnt_pcen, exp_pcen);
    chk({tag, "_pcRst_count"}, cnt_pcrst, 1);
    chk({tag, "_done_count"}, cnt_done, 1);
    chk({tag, "_bits_left"}, exp_bits.size(), 0);
    chk({tag, "_gaps_left"}, exp_gaps.size(), 0);
    chk({tag, "_busy_idle"}, busy8, 0);
    chk({tag, "_cs_idle"}, cs8, 1);
  endtask

  initial begin
    int t, pe, n9;
    logic [8:0] bits9;
    clear_rom();
    for (int i = 0; i < 4; i++) rom9[i] = mk(2'b11, 16'h0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", cs8, 1);
    chk("rst_dc", dc8, 1);
    chk("rst_mosi", mosi8, 0);
    chk("rst_pcEn", pcEn8, 0);
    chk("rst_pcRst", pcRst8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_cs9", cs9, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single command then halt
    clear_rom();
    rom8[0] = mk(2'b00, 16'h00A5);
    run8("t1", 0);
    chk("t1_byte_literal", got_bits, 32'h0000_00A5);

    // 2: back-to-back command and data words
    clear_rom();
    rom8[0] = mk(2'b00, 16'h002C);
    rom8[1] = mk(2'b01, 16'h00FF);
    rom8[2] = mk(2'b01, 16'h0000);
    run8("t2", 0);
    chk("t2_bytes_literal", got_bits, 32'h002C_FF00);
    chk("t2_pcEn_literal", cnt_pcen, 3);
    chk("t2_edge_literal", cnt_edges, 24);

    // 3: delay of 5 ticks between words
    clear_rom();
    rom8[0] = mk(2'b01, 16'h0081);
    rom8[1] = mk(2'b10, 16'd5);
    rom8[2] = mk(2'b01, 16'h0001);
    run8("t3", 0);
    chk("t3_bytes_literal", got_bits, 32'h0000_8101);

    // 3b: zero delay releases cs only for NEXT/WAIT/DECODE
    rom8[1] = mk(2'b10, 16'd0);
    run8("t3b", 0);
    chk("t3b_gap_cycles", last_gap_cyc, 3);

    // 4: reset during bit 4, then replay from address 0
    clear_rom();
    rom8[0] = mk(2'b00, 16'h0055);
    build_model();
    mon_clear();
    mon_on = 1'b1;
    align_start();
    t = 0;
    while (cnt_edges < 4 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("t4_reach_bit4", t < 1000, 1);
    mon_on = 1'b0;
    chk("t4_first_bits", got_bits[3:0], 4'b0101);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_cs_after_rst", cs8, 1);
    chk("t4_busy_after_rst", busy8, 0);
    chk("t4_mosi_after_rst", mosi8, 0);
    pe = int'(pcEn8);
    repeat (10) begin
      @(negedge clk);
      pe += int'(pcEn8);
    end
    chk("t4_no_pcEn", pe, 0);
    run8("t4_replay", 0);
    chk("t4_replay_literal", got_bits, 32'h0000_0055);

    // 5: start pulsed while busy is ignored (tick during WAIT is ignored too)
    clear_rom();
    rom8[0] = mk(2'b00, 16'h00C3);
    rom8[1] = mk(2'b01, 16'h003C);
    run8("t5", 1);
    chk("t5_bytes_literal", got_bits, 32'h0000_C33C);

    // 6: 9-bit word
    rom9[0] = mk(2'b00, 16'h01F0);
    rom9[1] = mk(2'b11, 16'h0000);
    @(negedge clk);
    while (div != 3'd6) @(negedge clk);
    start9 = 1'b1;
    @(negedge clk);
    start9 = 1'b0;
    n9 = 0;
    bits9 = '0;
    t = 0;
    while (!done9 && t < 1000) begin
      @(negedge clk);
      t++;
      if (sclkEdge && !cs9 && busy9) begin
        bits9 = {bits9[7:0], mosi9};
        n9++;
        chk("t6_dc", dc9, 1);
      end
    end
    chk("t6_done_in_time", t < 1000, 1);
    chk("t6_edge_count", n9, 9);
    chk("t6_bits", bits9, 9'h1F0);
    @(negedge clk);
    chk("t6_busy_idle", busy9, 0);
    chk("t6_cs_idle", cs9, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
